// File: rtl/time_report_pkg.sv
// Shared ASCII constants and FSM state encoding for the time report framer.
// The checksum state and hex helper exist only when FRAMER_CHECKSUM_EN is defined.
package time_report_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_HI  = 3'd1,
        ST_SEND_LO  = 3'd2,
        ST_SEND_SEP = 3'd3,
        ST_SEND_EOL = 3'd4
`ifdef FRAMER_CHECKSUM_EN
        , ST_SEND_CK = 3'd5
`endif
    } state_e;

`ifdef FRAMER_CHECKSUM_EN
    // Uppercase hex character for one nibble of the running XOR
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib > 4'd9) begin
            hex_ascii = 8'h37 + {4'h0, nib};
        end else begin
            hex_ascii = ASCII_ZERO + {4'h0, nib};
        end
    endfunction
`endif

endpackage

// File: rtl/time_report_framer_if.sv
// Byte-stream handshake between the framer and the downstream TX FIFO.
interface time_report_framer_if;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;

    modport master (output o_tx_data, output o_tx_valid, input i_tx_ready);
    modport slave  (input o_tx_data, input o_tx_valid, output i_tx_ready);
endinterface

// File: rtl/bcd_to_ascii.sv
// One BCD digit to its ASCII character; out-of-range digits become '?'.
module bcd_to_ascii
    import time_report_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] ascii
);
    assign ascii = (digit > 4'd9) ? ASCII_QMARK : (ASCII_ZERO + {4'h0, digit});
endmodule

// File: rtl/time_report_framer.sv
// Serialises a snapshot of BCD time fields into an ASCII line on a ready/valid byte stream.
// Define FRAMER_CHECKSUM_EN to append '*' and a two-char hex XOR checksum before the EOL.
module time_report_framer
    import time_report_pkg::*;
#(
    parameter int         NUM_FIELDS = 3,
    parameter logic [7:0] SEP_CHAR   = 8'h3A,
    parameter int         PERIOD     = 1,
    parameter bit         EOL_CRLF   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_trig_tick,
    input  logic                    i_req,
    input  logic [NUM_FIELDS*8-1:0] i_digits,
    time_report_framer_if.master    tx,
    output logic                    o_busy,
    output logic                    o_frame_done,
    output logic [7:0]              o_overrun_cnt
);
    localparam logic [7:0] PERIOD_M1  = 8'(PERIOD - 1);
    localparam logic [1:0] LAST_FIELD = 2'(NUM_FIELDS - 1);

    state_e                  state_r, nxt_state_s;
    logic [1:0]              field_r, nxt_field_s, sub_r, nxt_sub_s;
    logic [NUM_FIELDS*8-1:0] snap_r, src_s;
    logic [7:0]              period_cnt_r, tx_data_r, overrun_r, digit_byte_s, digit_char_s, char_s;
    logic [3:0]              nibble_s;
    logic                    tx_valid_r, busy_r, pending_r;
    logic                    accept_s, wrap_s, trig_s, last_s, done_s, start_s, busy_now_s;
`ifdef FRAMER_CHECKSUM_EN
    logic [7:0]              ck_r;
`endif

    assign accept_s   = tx_valid_r && tx.i_tx_ready;
    assign wrap_s     = i_trig_tick && (period_cnt_r == PERIOD_M1);
    assign trig_s     = i_req || wrap_s;
    assign busy_now_s = (state_r != ST_IDLE);
    assign last_s     = (state_r == ST_SEND_EOL) && (EOL_CRLF ? (sub_r == 2'd1) : (sub_r == 2'd0));
    assign done_s     = accept_s && last_s;
    // A queued or coincident trigger restarts straight from the last byte, keeping busy unbroken
    assign start_s    = ((state_r == ST_IDLE) && trig_s) || (done_s && (pending_r || trig_s));
    assign src_s      = start_s ? i_digits : snap_r;

    // Sequence step: which character follows the one currently presented
    always_comb begin
        nxt_state_s = state_r;
        nxt_field_s = field_r;
        nxt_sub_s   = sub_r;
        if (start_s) begin
            nxt_state_s = ST_SEND_HI;
            nxt_field_s = 2'd0;
            nxt_sub_s   = 2'd0;
        end else begin
            case (state_r)
                ST_SEND_HI: nxt_state_s = ST_SEND_LO;
                ST_SEND_LO: begin
                    nxt_sub_s = 2'd0;
                    if (field_r == LAST_FIELD) begin
`ifdef FRAMER_CHECKSUM_EN
                        nxt_state_s = ST_SEND_CK;
`else
                        nxt_state_s = ST_SEND_EOL;
`endif
                    end else begin
                        nxt_state_s = ST_SEND_SEP;
                    end
                end
                ST_SEND_SEP: begin
                    nxt_state_s = ST_SEND_HI;
                    nxt_field_s = field_r + 2'd1;
                end
`ifdef FRAMER_CHECKSUM_EN
                ST_SEND_CK: begin
                    if (sub_r == 2'd2) begin
                        nxt_state_s = ST_SEND_EOL;
                        nxt_sub_s   = 2'd0;
                    end else begin
                        nxt_sub_s = sub_r + 2'd1;
                    end
                end
`endif
                ST_SEND_EOL: begin
                    if (last_s) begin
                        nxt_state_s = ST_IDLE;
                    end else begin
                        nxt_sub_s = sub_r + 2'd1;
                    end
                end
                default: nxt_state_s = ST_IDLE;
            endcase
        end
    end

    assign digit_byte_s = src_s[{nxt_field_s, 3'b000} +: 8];
    assign nibble_s     = (nxt_state_s == ST_SEND_HI) ? digit_byte_s[7:4] : digit_byte_s[3:0];

    bcd_to_ascii u_bcd (.digit(nibble_s), .ascii(digit_char_s));

    // Character for the next state
    always_comb begin
        case (nxt_state_s)
            ST_SEND_HI, ST_SEND_LO: char_s = digit_char_s;
            ST_SEND_SEP:            char_s = SEP_CHAR;
            ST_SEND_EOL:            char_s = (EOL_CRLF && (nxt_sub_s == 2'd0)) ? ASCII_CR : ASCII_LF;
`ifdef FRAMER_CHECKSUM_EN
            ST_SEND_CK: begin
                case (nxt_sub_s)
                    2'd0:    char_s = ASCII_STAR;
                    2'd1:    char_s = hex_ascii(ck_r[7:4]);
                    default: char_s = hex_ascii(ck_r[3:0]);
                endcase
            end
`endif
            default:                char_s = 8'h00;
        endcase
    end

    // FSM, output registers, period counter and trigger bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            field_r      <= 2'd0;
            sub_r        <= 2'd0;
            snap_r       <= '0;
            period_cnt_r <= 8'd0;
            tx_data_r    <= 8'd0;
            tx_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
            pending_r    <= 1'b0;
            overrun_r    <= 8'd0;
`ifdef FRAMER_CHECKSUM_EN
            ck_r         <= 8'd0;
`endif
        end else begin
            if (i_trig_tick) begin
                period_cnt_r <= wrap_s ? 8'd0 : (period_cnt_r + 8'd1);
            end
            if (start_s || (accept_s && !done_s)) begin
                state_r    <= nxt_state_s;
                field_r    <= nxt_field_s;
                sub_r      <= nxt_sub_s;
                tx_data_r  <= char_s;
                tx_valid_r <= 1'b1;
                busy_r     <= 1'b1;
            end else if (done_s) begin
                state_r    <= ST_IDLE;
                tx_valid_r <= 1'b0;
                busy_r     <= 1'b0;
            end
            if (start_s) begin
                snap_r <= i_digits;
            end
`ifdef FRAMER_CHECKSUM_EN
            if (start_s) begin
                ck_r <= 8'd0;
            end else if (accept_s && ((state_r == ST_SEND_HI) || (state_r == ST_SEND_LO) ||
                                      (state_r == ST_SEND_SEP))) begin
                ck_r <= ck_r ^ tx_data_r;
            end
`endif
            // The pending slot is consumed on completion; a trigger in that same cycle refills it
            if (done_s) begin
                pending_r <= pending_r && trig_s;
            end else if (busy_now_s && trig_s) begin
                if (pending_r) begin
                    overrun_r <= (overrun_r == 8'hFF) ? 8'hFF : (overrun_r + 8'd1);
                end else begin
                    pending_r <= 1'b1;
                end
            end
        end
    end

    assign tx.o_tx_data  = tx_data_r;
    assign tx.o_tx_valid = tx_valid_r;
    assign o_busy        = busy_r;
    assign o_frame_done  = done_s && !rst;
    assign o_overrun_cnt = overrun_r;

endmodule

// File: tb/tb_time_report_framer.sv
// Bench for time_report_framer: fixed vectors, random backpressure against a frame model,
// pending/overrun, mid-frame reset and a PERIOD=3 instance for the periodic trigger.
`timescale 1ns/1ps
module tb_time_report_framer;
    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [23:0]  dig;
        logic [103:0] exp;
        int           len;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick, req, tick3, req3;
    logic [23:0] digits;
    logic        busy, fdone, busy3, fdone3;
    logic [7:0]  ovr, ovr3;
    int          checks = 0, failures = 0, done_cnt = 0, done3_cnt = 0, cyc = 0, done_cyc = 0;
    int          d0, c0, n;
    byte_q_t     got_q, exp_q, exp2_q;
    logic        hold_armed = 1'b0;
    logic [7:0]  held_data = 8'h00;
    logic [23:0] rdig, rdig2;
    vec_t        tbl[3];

    time_report_framer_if tx_if();
    time_report_framer_if tx3_if();

    always #5 clk = ~clk;

    time_report_framer u_dut (
        .clk(clk), .rst(rst), .i_trig_tick(tick), .i_req(req), .i_digits(digits),
        .tx(tx_if), .o_busy(busy), .o_frame_done(fdone), .o_overrun_cnt(ovr)
    );

    time_report_framer #(.PERIOD(3)) u_dut3 (
        .clk(clk), .rst(rst), .i_trig_tick(tick3), .i_req(req3), .i_digits(24'h563412),
        .tx(tx3_if), .o_busy(busy3), .o_frame_done(fdone3), .o_overrun_cnt(ovr3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] asc(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : (8'h30 + 8'(d));
    endfunction

    function automatic logic [7:0] hx(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + 8'(d)) : (8'h41 + 8'(d) - 8'd10);
    endfunction

    // Frame built straight from the line format: digit pairs, ':' between fields, EOL
    function automatic byte_q_t model_frame(input logic [23:0] dig);
        byte_q_t    q;
        logic [7:0] f, x;
        for (int k = 0; k < 3; k++) begin
            f = dig[8*k +: 8];
            q.push_back(asc(f[7:4]));
            q.push_back(asc(f[3:0]));
            if (k < 2) q.push_back(8'h3A);
        end
`ifdef FRAMER_CHECKSUM_EN
        x = 8'h00;
        foreach (q[i]) x = x ^ q[i];
        q.push_back(8'h2A);
        q.push_back(hx(x[7:4]));
        q.push_back(hx(x[3:0]));
`else
        x = 8'h00;
`endif
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    task automatic run_frame(input logic [23:0] dig, input byte_q_t exp);
        digits = dig;
        req = 1'b1;
        step();
        req = 1'b0;
        digits = 24'($urandom);
        for (int i = 0; i < exp.size(); i++) begin
            @(negedge clk);
            chk("frame_valid", 32'(tx_if.o_tx_valid), 32'd1);
            chk("frame_byte", 32'(tx_if.o_tx_data), 32'(exp[i]));
            chk("frame_done", 32'(fdone), 32'(i == exp.size() - 1));
            chk("frame_busy", 32'(busy), 32'd1);
            step();
        end
        @(negedge clk);
        chk("frame_end_valid", 32'(tx_if.o_tx_valid), 32'd0);
        chk("frame_end_busy", 32'(busy), 32'd0);
        step();
    endtask

    // Stream monitor: accepted bytes, completion pulses and hold-under-backpressure
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst && hold_armed) begin
                chk("hold_valid", 32'(tx_if.o_tx_valid), 32'd1);
                chk("hold_data", 32'(tx_if.o_tx_data), 32'(held_data));
            end
            hold_armed = !rst && tx_if.o_tx_valid && !tx_if.i_tx_ready;
            held_data  = tx_if.o_tx_data;
            if (!rst && tx_if.o_tx_valid && tx_if.i_tx_ready) got_q.push_back(tx_if.o_tx_data);
            if (fdone) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (fdone3) done3_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick = 1'b0; req = 1'b0; tick3 = 1'b0; req3 = 1'b0; digits = 24'h0;
        tx_if.i_tx_ready = 1'b1; tx3_if.i_tx_ready = 1'b1;
`ifdef FRAMER_CHECKSUM_EN
        tbl[0] = '{24'h563412, 104'h31323A33343A3536_2A3037_0D0A, 13};
        tbl[1] = '{24'h005A09, 104'h30393A353F3A3030_2A3033_0D0A, 13};
        tbl[2] = '{24'h9900FF, 104'h3F3F3A30303A3939_2A3030_0D0A, 13};
`else
        tbl[0] = '{24'h563412, 104'h31323A33343A35360D0A, 10};
        tbl[1] = '{24'h005A09, 104'h30393A353F3A30300D0A, 10};
        tbl[2] = '{24'h9900FF, 104'h3F3F3A30303A39390D0A, 10};
`endif
        rst = 1'b1;
        req = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_valid", 32'(tx_if.o_tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(fdone), 32'd0);
        chk("rst_data", 32'(tx_if.o_tx_data), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        step();
        rst = 1'b0;
        req = 1'b0;
        step();

        for (int v = 0; v < 3; v++) begin
            exp_q.delete();
            for (int i = 0; i < tbl[v].len; i++) exp_q.push_back(tbl[v].exp[8*(tbl[v].len-1-i) +: 8]);
            run_frame(tbl[v].dig, exp_q);
        end

        // Random backpressure and mid-frame digit churn
        for (int f = 0; f < 8; f++) begin
            rdig = 24'($urandom);
            exp_q = model_frame(rdig);
            got_q.delete();
            d0 = done_cnt;
            digits = rdig;
            req = 1'b1;
            step();
            req = 1'b0;
            n = 0;
            while (done_cnt == d0 && n < 400) begin
                tx_if.i_tx_ready = 1'($urandom_range(0, 1));
                digits = 24'($urandom);
                step();
                n++;
            end
            tx_if.i_tx_ready = 1'b1;
            chk("rand_timeout", 32'(n < 400), 32'd1);
            chk("rand_len", 32'(got_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                chk("rand_byte", 32'(got_q[i]), 32'(exp_q[i]));
            step();
        end

        // Three triggers in a row: one pending frame back-to-back, one overrun
        rdig = 24'h563412;
        rdig2 = 24'h090807;
        exp_q = model_frame(rdig);
        exp2_q = model_frame(rdig2);
        foreach (exp2_q[i]) exp_q.push_back(exp2_q[i]);
        got_q.delete();
        d0 = done_cnt;
        digits = rdig;
        req = 1'b1;
        step();
        c0 = cyc + 1;
        digits = rdig2;
        step();
        step();
        req = 1'b0;
        n = 0;
        while (done_cnt < d0 + 2 && n < 100) begin
            step();
            n++;
        end
        chk("pend_frames", 32'(done_cnt - d0), 32'd2);
        chk("pend_gap", 32'(done_cyc - c0), 32'(exp_q.size() - 1));
        chk("pend_len", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("pend_byte", 32'(got_q[i]), 32'(exp_q[i]));
        chk("pend_ovr", 32'(ovr), 32'd1);
        repeat (2) step();

        // Reset at byte 4 aborts; a request during reset is ignored
        d0 = done_cnt;
        digits = 24'h000000;
        req = 1'b1;
        step();
        req = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_done_now", 32'(fdone), 32'd0);
        step();
        req = 1'b1;
        @(negedge clk);
        chk("abort_valid", 32'(tx_if.o_tx_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ovr", 32'(ovr), 32'd0);
        step();
        rst = 1'b0;
        req = 1'b0;
        @(negedge clk);
        chk("abort_ign_req", 32'(tx_if.o_tx_valid), 32'd0);
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        step();
        rdig = 24'($urandom);
        run_frame(rdig, model_frame(rdig));

        // PERIOD=3: one frame per third tick; req on the wrap still gives one frame
        for (int k = 0; k < 6; k++) begin
            tick3 = 1'b1;
            step();
            tick3 = 1'b0;
            @(negedge clk);
            chk("per_valid", 32'(tx3_if.o_tx_valid), 32'(k % 3 == 2));
            repeat (16) step();
        end
        chk("per_frames", 32'(done3_cnt), 32'd2);
        d0 = done3_cnt;
        tick3 = 1'b1; step(); tick3 = 1'b0; step();
        tick3 = 1'b1; step(); tick3 = 1'b0; step();
        tick3 = 1'b1; req3 = 1'b1; step(); tick3 = 1'b0; req3 = 1'b0;
        repeat (50) step();
        chk("per_coincident", 32'(done3_cnt - d0), 32'd1);
        chk("per_ovr", 32'(ovr3), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/time_report_framer.md
TIME_REPORT_FRAMER -- requirements
Module: time_report_framer

Interface
REQ-001 SHALL have parameter NUM_FIELDS, default 3, meaning the number of 2-digit time fields per frame (1..4; order hour, min, sec, msec).
REQ-002 SHALL have parameter SEP_CHAR, default 8'h3A, meaning the ASCII separator emitted between fields.
REQ-003 SHALL have parameter PERIOD, default 1, meaning the number of i_trig_tick pulses per periodic frame (1..255).
REQ-004 SHALL have parameter EOL_CRLF, default 1, meaning the end of line: 1 = CR LF (8'h0D 8'h0A), 0 = LF only.
REQ-005 SHALL have port clk  input  1  system clock; one clock domain, and all logic SHALL run on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port i_trig_tick  input  1  single-cycle periodic trigger (e.g. 1 s tick).
REQ-008 SHALL have port i_req  input  1  single-cycle on-demand frame request.
REQ-009 SHALL have port i_digits  input  NUM_FIELDS*8  BCD digits; field k occupies bits [8k+7:8k], with the tens digit in the upper nibble; field 0 is the most significant field (sent first).
REQ-010 SHALL have port i_tx_ready  input  1  downstream TX FIFO can accept a byte.
REQ-011 SHALL have port o_tx_data  output  8  ASCII byte.
REQ-012 SHALL have port o_tx_valid  output  1  o_tx_data is valid.
REQ-013 SHALL have port o_busy  output  1  a frame is in progress.
REQ-014 SHALL have port o_frame_done  output  1  one-cycle pulse when the last byte of a frame is accepted.
REQ-015 SHALL have port o_overrun_cnt  output  8  saturating count of dropped triggers.

Function
REQ-016 The frame SHALL be: for each field, tens char then units char; SEP_CHAR between fields (none after the last); then the EOL characters.
REQ-017 Frame length SHALL be 3*NUM_FIELDS-1+(EOL_CRLF?2:1) bytes, plus 3 when checksum is enabled.
REQ-018 A BCD digit 0..9 SHALL map to 8'h30+d; a digit >9 SHALL map to 8'h3F ('?').
REQ-019 The period counter SHALL count i_trig_tick pulses from 0 to PERIOD-1, wrap to 0, and raise a periodic trigger on the wrap.
REQ-020 i_req and a periodic trigger in the same cycle SHALL produce exactly one trigger.
REQ-021 The FSM SHALL have states IDLE, SEND_HI, SEND_LO, SEND_SEP, SEND_EOL, plus SEND_CK when checksum is enabled.
REQ-022 A trigger in IDLE in cycle t SHALL snapshot i_digits at the end of cycle t; o_tx_valid SHALL be high from cycle t+1 with the first character.
REQ-023 The frame SHALL use only the snapshot; i_digits changes mid-frame SHALL NOT affect it.
REQ-024 A byte SHALL transfer only on o_tx_valid && i_tx_ready; while i_tx_ready is low, o_tx_data and o_tx_valid SHALL hold.
REQ-025 o_tx_valid SHALL stay high continuously between the first and last byte of a frame, with no bubbles when i_tx_ready is held high.
REQ-026 A trigger while busy SHALL set a one-deep pending flag; the pending frame SHALL start in the cycle after o_frame_done, with a fresh snapshot.
REQ-027 A trigger while busy with pending already set SHALL increment o_overrun_cnt, saturating at 255.
REQ-028 o_busy SHALL be high from cycle t+1 through the cycle of the last byte's acceptance.

Reset
REQ-029 While rst is high, the FSM SHALL be IDLE, and o_tx_valid, o_busy, o_frame_done, o_tx_data, o_overrun_cnt, the pending flag and the period counter SHALL all be 0.
REQ-030 A reset asserted mid-frame SHALL abort the frame with no completion pulse; triggers during reset SHALL be ignored.

Configuration
REQ-031 With FRAMER_CHECKSUM_EN defined, '*' followed by two uppercase hex ASCII chars of the XOR of all preceding frame bytes SHALL precede the EOL; without it, neither the state nor the logic SHALL exist.

Structure
REQ-032 Package time_report_pkg SHALL hold the ASCII constants (CR, LF, '0', '?', '*') and the FSM state encoding.
REQ-033 Sub-module bcd_to_ascii (4-bit digit to 8-bit ASCII, per REQ-018) SHALL be instantiated for the character path.

Verification
REQ-034 With defaults, digits 8'h12,8'h34,8'h56, i_req pulse and ready high -> bytes 31 32 3A 33 34 3A 35 36 0D 0A in 10 consecutive cycles, o_frame_done on the last.
REQ-035 With PERIOD=3 -> one frame per 3 i_trig_tick pulses; i_req coincident with the wrap -> only one frame.
REQ-036 i_tx_ready toggled randomly -> identical byte sequence, with data held stable whenever valid && !ready.
REQ-037 Three triggers during one frame -> one pending frame follows immediately, and o_overrun_cnt=1.
REQ-038 rst asserted at byte 4 -> o_tx_valid=0 next cycle, no o_frame_done, and the next i_req produces a full frame.
REQ-039 Digit nibble 4'hA -> 8'h3F; with FRAMER_CHECKSUM_EN and digits 12:34:56 -> '*' plus the two hex chars of the XOR of the 8 preceding bytes, then CR LF.
